// File: rtl/nn_rd_pkg.sv
// Shared types and AXI constants for the nn_axi_burst_reader read engine.
//   rd_state_e     : engine FSM states
//   BURST_INCR     : AXI ARBURST encoding for incrementing bursts
//   RESP_OKAY      : AXI RRESP encoding for a good beat
//   BOUNDARY_BYTES : AXI bursts must not cross this address boundary
package nn_rd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } rd_state_e;

    localparam logic [1:0]  BURST_INCR     = 2'b01;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam int unsigned BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/nn_burst_len_calc.sv
// Combinational burst sizing: len_o = min(MAX_BURST, remain_i, beats left before the next
// 4 KB boundary). Result is a beat count (1..MAX_BURST), not AXI arlen.
//   offset_i : low 12 bits of the (beat-aligned) burst start address
//   remain_i : beats still to fetch for the command
//   len_o    : beats in the next burst
module nn_burst_len_calc
    import nn_rd_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned LEN_W     = 24
) (
    input  logic [11:0]      offset_i,
    input  logic [LEN_W-1:0] remain_i,
    output logic [8:0]       len_o
);

    localparam int unsigned Sh = $clog2(DATA_W / 8);

    logic [31:0] to_bnd;
    logic [31:0] rem;
    logic [31:0] best;

    always_comb begin
        to_bnd = (32'(BOUNDARY_BYTES) - 32'(offset_i)) >> Sh;
        rem    = 32'(remain_i);
        best   = 32'(MAX_BURST);
        if (rem < best) begin
            best = rem;
        end
        if (to_bnd < best) begin
            best = to_bnd;
        end
        len_o = 9'(best);
    end

endmodule

// File: rtl/nn_axi_burst_reader.sv
// AXI4 read master: fetches one command (address, byte count) as a sequence of INCR bursts
// that never exceed MAX_BURST beats nor cross a 4 KB boundary, and streams the read data
// out on an AXI4-Stream port with TLAST on the final beat of the command.
//   cmd_*        : command handshake (accepted only while idle)
//   m_axi_ar*    : read address channel, one burst outstanding at a time
//   m_axi_r*     : read data channel, passed straight through to m_axis_*
//   m_axis_*     : output stream
//   busy/done    : status; done is a one-cycle pulse after the last beat
//   err          : sticky (bad RRESP or misplaced RLAST), cleared on next accept
//   interrupt    : level, set with done, cleared on next accept
// Optional: define NN_RD_PERF_CNT_EN to add perf_busy_cycles / perf_stall_cycles.
module nn_axi_burst_reader
    import nn_rd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned LEN_W     = 24
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_bytes,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
`ifdef NN_RD_PERF_CNT_EN
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              interrupt
);

    localparam int unsigned      Sh      = $clog2(DATA_W / 8);
    localparam logic [LEN_W-1:0] OneBeat = LEN_W'(1);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;     // start address of the current burst
    logic [LEN_W-1:0]  remain_q;   // beats left in the whole command
    logic [8:0]        burst_q;    // beats left in the current burst
    logic [7:0]        arlen_q;
    logic              err_q;
    logic              irq_q;
    logic              done_q;

    logic [ADDR_W-1:0] cmd_addr_al;
    logic [LEN_W-1:0]  cmd_beats;
    logic [ADDR_W-1:0] next_addr;
    logic [11:0]       calc_off;
    logic [LEN_W-1:0]  calc_remain;
    logic [8:0]        calc_len;
    logic              rd_hs;
    logic              last_beat;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cmd_addr[Sh-1:0];

    // The sizing unit always looks at the *next* burst: the new command while idle,
    // otherwise the burst that follows the current one.
    always_comb begin
        cmd_addr_al = {cmd_addr[ADDR_W-1:Sh], {Sh{1'b0}}};
        cmd_beats   = cmd_bytes >> Sh;
        next_addr   = addr_q + (ADDR_W'({1'b0, arlen_q} + 9'd1) << Sh);
        rd_hs       = (state_q == StData) && m_axi_rvalid && m_axis_tready;
        last_beat   = (burst_q == 9'd1);
        if (state_q == StIdle) begin
            calc_off    = cmd_addr_al[11:0];
            calc_remain = cmd_beats;
        end else begin
            calc_off    = next_addr[11:0];
            calc_remain = remain_q - OneBeat;
        end
    end

    nn_burst_len_calc #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) u_len_calc (
        .offset_i (calc_off),
        .remain_i (calc_remain),
        .len_o    (calc_len)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            burst_q  <= '0;
            arlen_q  <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr_al;
                        remain_q <= cmd_beats;
                        err_q    <= 1'b0;
                        irq_q    <= 1'b0;
                        if (cmd_beats == '0) begin
                            state_q <= StDone;
                        end else begin
                            arlen_q <= 8'(calc_len - 9'd1);
                            burst_q <= calc_len;
                            state_q <= StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (m_axi_arready) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (rd_hs) begin
                        // Flag only; the beat count alone decides when a burst ends.
                        if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat)) begin
                            err_q <= 1'b1;
                        end
                        remain_q <= remain_q - OneBeat;
                        burst_q  <= burst_q - 9'd1;
                        if (last_beat) begin
                            if (remain_q == OneBeat) begin
                                state_q <= StDone;
                            end else begin
                                addr_q  <= next_addr;
                                arlen_q <= 8'(calc_len - 9'd1);
                                burst_q <= calc_len;
                                state_q <= StAddr;
                            end
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    irq_q   <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready     = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign err           = err_q;
    assign interrupt     = irq_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(Sh);
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arvalid = (state_q == StAddr);
    assign m_axi_rready  = (state_q == StData) && m_axis_tready;
    assign m_axis_tvalid = (state_q == StData) && m_axi_rvalid;
    assign m_axis_tdata  = (state_q == StData) ? m_axi_rdata : '0;
    assign m_axis_tlast  = (state_q == StData) && (remain_q == OneBeat);

`ifdef NN_RD_PERF_CNT_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if ((state_q == StIdle) && cmd_valid) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (m_axis_tvalid && !m_axis_tready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_nn_axi_burst_reader.sv
// Self-checking bench for nn_axi_burst_reader: an AXI read-slave model feeds address-derived
// data, a scoreboard holds the expected AR bursts and stream beats, and a negedge monitor
// pops and compares them as the DUT produces them.
module tb_nn_axi_burst_reader;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned LEN_W     = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_bytes;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              busy;
    logic              done;
    logic              err;
    logic              interrupt;
`ifdef NN_RD_PERF_CNT_EN
    logic [31:0]       perf_busy_cycles;
    logic [31:0]       perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    nn_axi_burst_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_bytes     (cmd_bytes),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef NN_RD_PERF_CNT_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .busy          (busy),
        .done          (done),
        .err           (err),
        .interrupt     (interrupt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard
    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];
    logic [63:0] exp_data[$];
    logic        exp_last[$];

    // Slave knobs and state
    bit          gap_en        = 1'b0;
    int          tready_mode   = 0;   // 0: always ready, 1: toggle, 2: random
    int          resp_err_beat = -1;  // beat index within the command that returns SLVERR
    bit          early_rlast   = 1'b0;
    int          cmd_beat      = 0;
    bit          s_active      = 1'b0;
    logic [31:0] s_addr        = '0;
    int          s_len         = 0;
    int          s_beat        = 0;
    bit          ar_hs_s, r_hs_s;
    logic [31:0] ar_addr_s;
    logic [7:0]  ar_len_s;

    // Monitor statistics
    int          ar_cnt = 0, beat_cnt = 0, arvalid_cycles = 0, stall_exp = 0;
    bit          ar_wait_q = 1'b0;
    logic [31:0] ar_addr_prev;
    logic [7:0]  ar_len_prev;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {~a, a};
    endfunction

    // Independent splitting model: min(16 beats, remaining, beats to next 4 KB).
    function automatic void push_expect(input logic [31:0] addr, input int unsigned bytes);
        logic [31:0] a;
        int unsigned rem, len, to_bnd;
        a   = addr & ~32'h7;
        rem = bytes / 8;
        while (rem > 0) begin
            len    = (rem < MAX_BURST) ? rem : MAX_BURST;
            to_bnd = (4096 - (a & 32'hFFF)) / 8;
            if (to_bnd < len) len = to_bnd;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(8'(len - 1));
            for (int j = 0; j < int'(len); j++) begin
                exp_data.push_back(pat(a + 32'(j * 8)));
                exp_last.push_back(rem - 32'(j) == 1);
            end
            a   = a + 32'(len * 8);
            rem = rem - len;
        end
    endfunction

    // AXI read slave: sample handshakes at negedge, update drives just after posedge.
    always begin : slave
        @(negedge clk);
        ar_hs_s   = rst_n && m_axi_arvalid && m_axi_arready;
        r_hs_s    = rst_n && m_axi_rvalid && m_axi_rready;
        ar_addr_s = m_axi_araddr;
        ar_len_s  = m_axi_arlen;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            s_active      = 1'b0;
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_rresp   = 2'b00;
            m_axi_rdata   = '0;
            m_axis_tready = 1'b1;
        end else begin
            if (ar_hs_s) begin
                s_active = 1'b1;
                s_addr   = ar_addr_s;
                s_len    = int'(ar_len_s);
                s_beat   = 0;
            end
            if (r_hs_s) begin
                s_beat++;
                cmd_beat++;
                if (s_beat > s_len) s_active = 1'b0;
            end
            m_axi_arready = 1'($urandom_range(0, 1));
            if (!s_active) m_axi_rvalid = 1'b0;
            else if (!(m_axi_rvalid && !r_hs_s)) m_axi_rvalid = gap_en ? ($urandom_range(0, 3) != 0)
                                                                       : 1'b1;
            m_axi_rdata = pat(s_addr + 32'(s_beat * 8));
            m_axi_rlast = s_active && ((s_beat == s_len) || (early_rlast && s_beat == 0));
            m_axi_rresp = (s_active && cmd_beat == resp_err_beat) ? 2'b10 : 2'b00;
            case (tready_mode)
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard consumer
    always @(negedge clk) begin
        if (rst_n) begin
            if (ar_wait_q) begin
                tests_run++;
                if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== ar_addr_prev ||
                    m_axi_arlen !== ar_len_prev) begin
                    tests_failed++;
                    $display("FAIL ar_stable: got v=%b a=%h l=%0d required v=1 a=%h l=%0d",
                             m_axi_arvalid, m_axi_araddr, m_axi_arlen, ar_addr_prev, ar_len_prev);
                end
            end
            ar_wait_q    = m_axi_arvalid && !m_axi_arready;
            ar_addr_prev = m_axi_araddr;
            ar_len_prev  = m_axi_arlen;
            if (m_axi_arvalid) arvalid_cycles++;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt++;
                tests_run++;
                if (exp_ar_addr.size() == 0) begin
                    tests_failed++;
                    $display("FAIL ar_unexpected: got addr=%h len=%0d required none",
                             m_axi_araddr, m_axi_arlen);
                end else begin
                    logic [31:0] ea;
                    logic [7:0]  el;
                    ea = exp_ar_addr.pop_front();
                    el = exp_ar_len.pop_front();
                    if (m_axi_araddr !== ea || m_axi_arlen !== el || m_axi_arsize !== 3'd3 ||
                        m_axi_arburst !== 2'b01) begin
                        tests_failed++;
                        $display("FAIL ar_burst: got a=%h l=%0d sz=%0d bu=%b required a=%h l=%0d",
                                 m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, ea, el);
                    end
                end
            end
            if (m_axi_rvalid) begin
                tests_run++;
                if (m_axi_rready !== m_axis_tready || m_axis_tvalid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL r_passthru: got rready=%b tvalid=%b required rready=%b tvalid=1",
                             m_axi_rready, m_axis_tvalid, m_axis_tready);
                end
                if (!m_axis_tready) stall_exp++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beat_cnt++;
                tests_run++;
                if (exp_data.size() == 0) begin
                    tests_failed++;
                    $display("FAIL beat_unexpected: got data=%h required none", m_axis_tdata);
                end else begin
                    logic [63:0] ed;
                    logic        elast;
                    ed    = exp_data.pop_front();
                    elast = exp_last.pop_front();
                    if (m_axis_tdata !== ed || m_axis_tlast !== elast) begin
                        tests_failed++;
                        $display("FAIL beat: got data=%h last=%b required data=%h last=%b",
                                 m_axis_tdata, m_axis_tlast, ed, elast);
                    end
                end
            end
        end else begin
            ar_wait_q = 1'b0;
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [23:0] b, output bit ok);
        stall_exp = 0;
        cmd_beat  = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_bytes = b;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [16:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {cmd_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, busy, done,
               err, interrupt, m_axi_arsize, m_axi_arburst, m_axi_arlen == 8'd0,
               m_axi_araddr == 32'd0, m_axis_tdata == 64'd0};
        tests_run++;
        if (obs !== {1'b1, 8'b0, 3'd3, 2'b01, 3'b111}) begin
            tests_failed++;
            $display("FAIL reset_state: got %b required %b", obs, {1'b1, 8'b0, 3'd3, 2'b01, 3'b111});
        end
`ifdef NN_RD_PERF_CNT_EN
        tests_run++;
        if (perf_busy_cycles !== 32'd0 || perf_stall_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_busy_cycles,
                     perf_stall_cycles);
        end
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_long_command;
        int cyc, ar0, b0;
        bit ok_c, ok_d;
        gap_en = 1'b1;
        tready_mode = 0;
        ar0 = ar_cnt;
        b0  = beat_cnt;
        push_expect(32'h1000, 1024);
        send_cmd(32'h1000, 24'd1024, ok_c);
        wait_done(3000, cyc, ok_d);
        tests_run++;
        if (!ok_c || !ok_d || interrupt !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_done: got acc=%b done=%b irq=%b err=%b required 1 1 1 0",
                     ok_c, ok_d, interrupt, err);
        end
        tests_run++;
        if (ar_cnt - ar0 != 8 || beat_cnt - b0 != 128 || exp_data.size() != 0) begin
            tests_failed++;
            $display("FAIL long_counts: got bursts=%0d beats=%0d left=%0d required 8 128 0",
                     ar_cnt - ar0, beat_cnt - b0, exp_data.size());
        end
`ifdef NN_RD_PERF_CNT_EN
        tests_run++;
        if (perf_busy_cycles !== 32'(cyc - 1)) begin
            tests_failed++;
            $display("FAIL long_perf_busy: got %0d required %0d", perf_busy_cycles, cyc - 1);
        end
`endif
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || interrupt !== 1'b1) begin
            tests_failed++;
            $display("FAIL long_pulse: got done=%b irq=%b required done=0 irq=1", done, interrupt);
        end
    endtask

    task automatic test_4k_boundary;
        int cyc, ar0;
        bit ok_c, ok_d;
        tready_mode = 2;
        ar0 = ar_cnt;
        push_expect(32'h0FF0, 64);
        send_cmd(32'h0FF0, 24'd64, ok_c);
        wait_done(1000, cyc, ok_d);
        tests_run++;
        if (!ok_c || !ok_d || ar_cnt - ar0 != 2 || exp_data.size() != 0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL boundary: got acc=%b done=%b bursts=%0d left=%0d err=%b req 1 1 2 0 0",
                     ok_c, ok_d, ar_cnt - ar0, exp_data.size(), err);
        end
        tready_mode = 0;
    endtask

    task automatic test_zero_bytes;
        int cyc, arv0;
        bit ok_c, ok_d;
        arv0 = arvalid_cycles;
        send_cmd(32'h6000, 24'd0, ok_c);
        wait_done(20, cyc, ok_d);
        tests_run++;
        if (!ok_c || !ok_d || cyc != 2) begin
            tests_failed++;
            $display("FAIL zero_latency: got acc=%b done=%b cycles=%0d required 1 1 2",
                     ok_c, ok_d, cyc);
        end
        tests_run++;
        if (arvalid_cycles != arv0 || err !== 1'b0 || interrupt !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_flags: got arvalid_cyc=%0d err=%b irq=%b required 0 0 1",
                     arvalid_cycles - arv0, err, interrupt);
        end
    endtask

    task automatic test_rresp_error;
        int cyc, b0;
        bit ok_c, ok_d;
        b0 = beat_cnt;
        resp_err_beat = 2;
        push_expect(32'h2000, 32);
        send_cmd(32'h2000, 24'd32, ok_c);
        wait_done(500, cyc, ok_d);
        resp_err_beat = -1;
        tests_run++;
        if (!ok_d || err !== 1'b1 || beat_cnt - b0 != 4 || exp_data.size() != 0) begin
            tests_failed++;
            $display("FAIL rresp_err: got done=%b err=%b beats=%0d required 1 1 4",
                     ok_d, err, beat_cnt - b0);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: got %b required 1", err);
        end
        early_rlast = 1'b1;
        push_expect(32'h2100, 32);
        send_cmd(32'h2100, 24'd32, ok_c);
        @(negedge clk);
        tests_run++;
        if (err !== 1'b0 || interrupt !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: got err=%b irq=%b required 0 0", err, interrupt);
        end
        wait_done(500, cyc, ok_d);
        early_rlast = 1'b0;
        tests_run++;
        if (!ok_d || err !== 1'b1 || exp_data.size() != 0) begin
            tests_failed++;
            $display("FAIL rlast_early: got done=%b err=%b required 1 1", ok_d, err);
        end
    endtask

    task automatic test_tready_toggle;
        int cyc, b0;
        bit ok_c, ok_d;
        gap_en = 1'b0;
        tready_mode = 1;
        b0 = beat_cnt;
        push_expect(32'h3000, 128);
        send_cmd(32'h3000, 24'd128, ok_c);
        wait_done(500, cyc, ok_d);
        tests_run++;
        if (!ok_d || beat_cnt - b0 != 16 || exp_data.size() != 0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL tready_toggle: got done=%b beats=%0d err=%b required 1 16 0",
                     ok_d, beat_cnt - b0, err);
        end
`ifdef NN_RD_PERF_CNT_EN
        tests_run++;
        if (perf_stall_cycles !== 32'(stall_exp)) begin
            tests_failed++;
            $display("FAIL perf_stall: got %0d required %0d", perf_stall_cycles, stall_exp);
        end
`endif
        tready_mode = 0;
        gap_en = 1'b1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit ok_c, ok_d;
        push_expect(32'h7004, 37);  // aligned to 0x7000, 4 beats, 5 bytes dropped
        send_cmd(32'h7004, 24'd37, ok_c);
        wait_done(500, cyc, ok_d);
        tests_run++;
        if (!ok_d || interrupt !== 1'b1 || exp_data.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_first: got done=%b irq=%b left=%0d required 1 1 0",
                     ok_d, interrupt, exp_data.size());
        end
        push_expect(32'h7100, 64);
        send_cmd(32'h7100, 24'd64, ok_c);
        cmd_valid = 1'b1;  // must be ignored while busy
        cmd_addr  = 32'hDEAD_0000;
        cmd_bytes = 24'd64;
        @(negedge clk);
        tests_run++;
        if (interrupt !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: got irq=%b busy=%b cmd_ready=%b required 0 1 0",
                     interrupt, busy, cmd_ready);
        end
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(500, cyc, ok_d);
        tests_run++;
        if (!ok_d || exp_data.size() != 0 || exp_ar_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_second: got done=%b left=%0d/%0d required 1 0/0",
                     ok_d, exp_data.size(), exp_ar_addr.size());
        end
    endtask

    task automatic test_reset_mid_data;
        int cyc, b0;
        bit ok_c, ok_d, reached;
        logic [4:0] obs;
        b0 = beat_cnt;
        push_expect(32'h4000, 256);
        send_cmd(32'h4000, 24'd256, ok_c);
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (beat_cnt - b0 >= 4 && m_axis_tvalid) begin
                reached = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("FAIL mid_data_reach: got beats=%0d required >=4", beat_cnt - b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {cmd_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid, busy};
        tests_run++;
        if (obs !== 5'b10000) begin
            tests_failed++;
            $display("FAIL mid_reset: got %b required 10000", obs);
        end
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_data.delete();
        exp_last.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_expect(32'h5000, 64);
        send_cmd(32'h5000, 24'd64, ok_c);
        wait_done(500, cyc, ok_d);
        tests_run++;
        if (!ok_c || !ok_d || exp_data.size() != 0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_cmd: got acc=%b done=%b left=%0d err=%b required 1 1 0 0",
                     ok_c, ok_d, exp_data.size(), err);
        end
    endtask

    initial begin
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_bytes     = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
        m_axi_rdata   = '0;
        m_axis_tready = 1'b1;
        test_reset;
        test_long_command;
        test_4k_boundary;
        test_zero_bytes;
        test_rresp_error;
        test_tready_toggle;
        test_back_to_back;
        test_reset_mid_data;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
